r_alu_arbiter: RTL

Shares one R-type ALU between NUM_REQ requesters with round-robin arbitration and valid/ready handshakes on both sides. A requester presents a full 32-bit R-type instruction word plus two operand values. The block registers the winning request, evaluates it in the shared ALU and returns a tagged result. It sits between the register-read stage of multiple issuing units and the single R-type execution datapath.

---
 rtl/r_alu_pkg.sv | 58 +++++
 rtl/r_alu_core.sv | 33 +++
 rtl/r_alu_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/r_alu_pkg.sv
// Shared types and decode helpers for the round-robin R-type ALU arbiter.
// The legality check helper is only used when R_ALU_ILLEGAL_CHECK_EN is defined.
package r_alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } state_e;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [2:0] F3_ADDSUB  = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // Bit 30 only selects sub/sra; it is ignored for every other funct3.
  function automatic alu_op_e decode(input logic [31:0] instr);
    alu_op_e op;
    op = ALU_ADD;
    case (instr[14:12])
      F3_ADDSUB: op = instr[30] ? ALU_SUB : ALU_ADD;
      F3_SLL:    op = ALU_SLL;
      F3_SLT:    op = ALU_SLT;
      F3_SLTU:   op = ALU_SLTU;
      F3_XOR:    op = ALU_XOR;
      F3_SR:     op = instr[30] ? ALU_SRA : ALU_SRL;
      F3_OR:     op = ALU_OR;
      F3_AND:    op = ALU_AND;
      default:   op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic illegal(input logic [31:0] instr);
    logic [2:0] f3;
    f3 = instr[14:12];
    return (instr[6:0] != OPC_RTYPE) || instr[31] || (instr[29:25] != 5'd0) ||
           (instr[30] && (f3 != F3_ADDSUB) && (f3 != F3_SR));
  endfunction

endpackage

// File: rtl/r_alu_core.sv
// Purely combinational R-type ALU; shift amount is b[4:0].
module r_alu_core
  import r_alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  alu_op_e          op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic [XLEN-1:0]  y
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << shamt;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = XLEN'($signed(a) >>> shamt);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/r_alu_arbiter.sv
// Round-robin arbiter sharing one R-type ALU among NUM_REQ requesters.
// Define R_ALU_ILLEGAL_CHECK_EN to flag malformed instructions on rsp_err.
module r_alu_arbiter
  import r_alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned XLEN    = 32,
  localparam int unsigned IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0][31:0]       req_instr,
  input  logic [NUM_REQ-1:0][XLEN-1:0]   req_rs1,
  input  logic [NUM_REQ-1:0][XLEN-1:0]   req_rs2,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [XLEN-1:0]                rsp_result,
  output logic [IDW-1:0]                 rsp_id,
  output logic                           rsp_err
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   id_q;
  logic [31:0]      instr_q;
  logic [XLEN-1:0]  rs1_q, rs2_q;

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   cand;
  logic             slot_free;
  logic             accept;

  // Search starts at rr_ptr and wraps, so the first hit is the round-robin winner.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDW'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign slot_free = (state_q == ST_IDLE) || rsp_ready;
  assign accept    = slot_free && grant_found && rst_n;
  assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = accept ? ST_RESP : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      instr_q  <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        instr_q  <= req_instr[grant_idx];
        rs1_q    <= req_rs1[grant_idx];
        rs2_q    <= req_rs2[grant_idx];
        id_q     <= grant_idx;
        rr_ptr_q <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  alu_op_e          op;
  logic [XLEN-1:0]  alu_y;
  logic             unused_instr;

  always_comb op = decode(instr_q);
  assign unused_instr = ^instr_q;

  r_alu_core #(.XLEN(XLEN)) u_core (
    .op (op),
    .a  (rs1_q),
    .b  (rs2_q),
    .y  (alu_y)
  );

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = id_q;

`ifdef R_ALU_ILLEGAL_CHECK_EN
  logic bad;
  // The reset value of instr_q is itself illegal, so the flag is qualified by RESP.
  assign bad        = illegal(instr_q);
  assign rsp_err    = bad && (state_q == ST_RESP);
  assign rsp_result = bad ? '0 : alu_y;
`else
  assign rsp_err    = 1'b0;
  assign rsp_result = alu_y;
`endif

endmodule
